// File: rtl/pid_pkg.sv
// Shared widths, coefficient record and signed saturation helper for the PID filter.
package pid_pkg;

  localparam int PID_N_CHAN = 8;
  localparam int PID_W_DATA = 18;
  localparam int PID_W_COEF = 16;
  localparam int PID_W_INT  = 26;
  localparam int PID_W_OUT  = 18;

  typedef struct packed {
    logic signed [PID_W_COEF-1:0] setpoint;
    logic signed [PID_W_COEF-1:0] p;
    logic signed [PID_W_COEF-1:0] i;
    logic signed [PID_W_COEF-1:0] d;
  } pid_coef_t;

  // Clamp x to a w-bit signed range; sym drops the most negative code.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int w,
                                                  input logic sym);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = sym ? -hi : -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/sat_clip.sv
// Signed arithmetic right shift followed by saturation to W_OUT bits.
module sat_clip
  import pid_pkg::*;
#(
  parameter int W_IN      = 44,
  parameter int W_OUT     = 18,
  parameter int SHIFT     = 0,
  parameter bit SYMMETRIC = 1'b0
) (
  input  logic signed [W_IN-1:0]  in_i,
  output logic signed [W_OUT-1:0] out_o
);

  assign out_o = W_OUT'(saturate(64'(in_i) >>> SHIFT, W_OUT, SYMMETRIC));

endmodule

// File: rtl/pid_filter_mc.sv
// Time-multiplexed multi-channel PID filter, one sample per cycle, five-stage pipeline.
// Define PID_INT_CLAMP_EN for a symmetric saturating integrator; otherwise it wraps.
module pid_filter_mc
  import pid_pkg::*;
#(
  parameter int N_CHAN = PID_N_CHAN,
  parameter int W_CHAN = $clog2(N_CHAN),
  parameter int W_DATA = PID_W_DATA,
  parameter int W_COEF = PID_W_COEF,
  parameter int W_INT  = PID_W_INT,
  parameter int W_OUT  = PID_W_OUT,
  parameter int SHIFT  = 0
) (
  input  logic                     clk_in,
  input  logic                     n_rst_in,
  input  logic                     data_dv_in,
  input  logic signed [W_DATA-1:0] data_in,
  input  logic [W_CHAN-1:0]        chan_in,
  input  logic [N_CHAN-1:0]        lock_en_in,
  input  logic                     cfg_wr_in,
  input  logic [W_CHAN-1:0]        cfg_chan_in,
  input  logic signed [W_COEF-1:0] cfg_setpoint_in,
  input  logic signed [W_COEF-1:0] cfg_p_in,
  input  logic signed [W_COEF-1:0] cfg_i_in,
  input  logic signed [W_COEF-1:0] cfg_d_in,
  output logic signed [W_OUT-1:0]  data_out,
  output logic [W_CHAN-1:0]        chan_out,
  output logic                     data_dv_out
);

  localparam int W_E     = W_DATA + 1;
  localparam int W_DD    = W_DATA + 2;
  localparam int W_ACC   = ((W_INT > W_E) ? W_INT : W_E) + 1;
  localparam int W_PE    = W_COEF + W_E;
  localparam int W_PI    = W_COEF + W_INT;
  localparam int W_PD    = W_COEF + W_DD;
  localparam int W_SUM_A = W_COEF + W_INT + 2;
  // Keep the sum wide enough for the D/P products when the integrator is narrow.
  localparam int W_SUM   = (W_SUM_A > W_PD + 2) ? W_SUM_A : W_PD + 2;

  pid_coef_t coef_q [N_CHAN];
  logic      cfg_ok;
  logic      in_ok;

  assign cfg_ok = int'(cfg_chan_in) < N_CHAN;
  assign in_ok  = int'(chan_in) < N_CHAN;

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      for (int c = 0; c < N_CHAN; c++) coef_q[c] <= '0;
    end else if (cfg_wr_in && cfg_ok) begin
      coef_q[cfg_chan_in] <= '{setpoint: cfg_setpoint_in, p: cfg_p_in,
                               i: cfg_i_in, d: cfg_d_in};
    end
  end

  // S0: capture sample, tag, lock bit and coefficients; form the error.
  pid_coef_t               coef_rd;
  logic signed [W_E-1:0]   e_d;
  logic                    vld_s0_q, lock_s0_q;
  logic [W_CHAN-1:0]       chan_s0_q;
  logic signed [W_E-1:0]   e_s0_q;
  logic signed [W_COEF-1:0] p_s0_q, i_s0_q, dc_s0_q;

  assign coef_rd = coef_q[chan_in];
  assign e_d     = W_E'($signed(coef_rd.setpoint)) - W_E'(data_in);

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      vld_s0_q  <= 1'b0;
      lock_s0_q <= 1'b0;
      chan_s0_q <= '0;
      e_s0_q    <= '0;
      p_s0_q    <= '0;
      i_s0_q    <= '0;
      dc_s0_q   <= '0;
    end else begin
      vld_s0_q <= data_dv_in && in_ok;
      if (data_dv_in && in_ok) begin
        lock_s0_q <= lock_en_in[chan_in];
        chan_s0_q <= chan_in;
        e_s0_q    <= e_d;
        p_s0_q    <= coef_rd.p;
        i_s0_q    <= coef_rd.i;
        dc_s0_q   <= coef_rd.d;
      end
    end
  end

  // S1: read-modify-write of the channel state within one stage.
  logic signed [W_INT-1:0] integ_q [N_CHAN];
  logic signed [W_E-1:0]   eprev_q [N_CHAN];
  logic signed [W_INT-1:0] integ_n_d;
  logic signed [W_DD-1:0]  dd_d;

  assign dd_d = W_DD'(e_s0_q) - W_DD'(eprev_q[chan_s0_q]);

`ifdef PID_INT_CLAMP_EN
  logic signed [W_ACC-1:0] integ_sum_d;
  assign integ_sum_d = W_ACC'(integ_q[chan_s0_q]) + W_ACC'(e_s0_q);
  sat_clip #(.W_IN(W_ACC), .W_OUT(W_INT), .SHIFT(0), .SYMMETRIC(1'b1)) u_int_clamp (
    .in_i  (integ_sum_d),
    .out_o (integ_n_d)
  );
`else
  assign integ_n_d = integ_q[chan_s0_q] + W_INT'(e_s0_q);
`endif

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      for (int c = 0; c < N_CHAN; c++) begin
        integ_q[c] <= '0;
        eprev_q[c] <= '0;
      end
    end else if (vld_s0_q) begin
      integ_q[chan_s0_q] <= lock_s0_q ? integ_n_d : '0;
      eprev_q[chan_s0_q] <= lock_s0_q ? e_s0_q : '0;
    end
  end

  logic                     vld_s1_q;
  logic [W_CHAN-1:0]        chan_s1_q;
  logic signed [W_E-1:0]    e_s1_q;
  logic signed [W_INT-1:0]  integ_s1_q;
  logic signed [W_DD-1:0]   dd_s1_q;
  logic signed [W_COEF-1:0] p_s1_q, i_s1_q, dc_s1_q;

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      vld_s1_q   <= 1'b0;
      chan_s1_q  <= '0;
      e_s1_q     <= '0;
      integ_s1_q <= '0;
      dd_s1_q    <= '0;
      p_s1_q     <= '0;
      i_s1_q     <= '0;
      dc_s1_q    <= '0;
    end else begin
      vld_s1_q   <= vld_s0_q && lock_s0_q;
      chan_s1_q  <= chan_s0_q;
      e_s1_q     <= e_s0_q;
      integ_s1_q <= integ_n_d;
      dd_s1_q    <= dd_d;
      p_s1_q     <= p_s0_q;
      i_s1_q     <= i_s0_q;
      dc_s1_q    <= dc_s0_q;
    end
  end

  // S2: products.  S3: sum.  Output: shift, saturate, register.
  logic                    vld_s2_q, vld_s3_q;
  logic [W_CHAN-1:0]       chan_s2_q, chan_s3_q;
  logic signed [W_PE-1:0]  pe_s2_q;
  logic signed [W_PI-1:0]  pi_s2_q;
  logic signed [W_PD-1:0]  pd_s2_q;
  logic signed [W_SUM-1:0] sum_s3_q;
  logic signed [W_OUT-1:0] sat_d;

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      vld_s2_q  <= 1'b0;
      chan_s2_q <= '0;
      pe_s2_q   <= '0;
      pi_s2_q   <= '0;
      pd_s2_q   <= '0;
      vld_s3_q  <= 1'b0;
      chan_s3_q <= '0;
      sum_s3_q  <= '0;
    end else begin
      vld_s2_q  <= vld_s1_q;
      chan_s2_q <= chan_s1_q;
      pe_s2_q   <= W_PE'(p_s1_q) * W_PE'(e_s1_q);
      pi_s2_q   <= W_PI'(i_s1_q) * W_PI'(integ_s1_q);
      pd_s2_q   <= W_PD'(dc_s1_q) * W_PD'(dd_s1_q);
      vld_s3_q  <= vld_s2_q;
      chan_s3_q <= chan_s2_q;
      sum_s3_q  <= W_SUM'(pe_s2_q) + W_SUM'(pi_s2_q) + W_SUM'(pd_s2_q);
    end
  end

  sat_clip #(.W_IN(W_SUM), .W_OUT(W_OUT), .SHIFT(SHIFT), .SYMMETRIC(1'b0)) u_out_sat (
    .in_i  (sum_s3_q),
    .out_o (sat_d)
  );

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      data_out    <= '0;
      chan_out    <= '0;
      data_dv_out <= 1'b0;
    end else begin
      data_dv_out <= vld_s3_q;
      if (vld_s3_q) begin
        data_out <= sat_d;
        chan_out <= chan_s3_q;
      end
    end
  end

endmodule

// File: tb/tb_pid_filter_mc.sv
// Bench for pid_filter_mc: default-width instance (A) and a narrow-integrator,
// six-channel instance (B); scoreboard queues checked against output pulses.
module tb_pid_filter_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               dv_a_in, cfg_wr_a, dv_a_out;
  logic signed [17:0] data_a_in, data_a_out;
  logic [2:0]         chan_a_in, cfg_chan_a, chan_a_out;
  logic [7:0]         lock_a, lock_mask_a;
  logic signed [15:0] cfg_sp_a, cfg_p_a, cfg_i_a, cfg_d_a;

  logic               dv_b_in, cfg_wr_b, dv_b_out;
  logic signed [17:0] data_b_in, data_b_out;
  logic [2:0]         chan_b_in, cfg_chan_b, chan_b_out;
  logic [5:0]         lock_b;
  logic signed [15:0] cfg_sp_b, cfg_p_b, cfg_i_b, cfg_d_b;

  pid_filter_mc u_dut_a (
    .clk_in(clk), .n_rst_in(n_rst), .data_dv_in(dv_a_in), .data_in(data_a_in),
    .chan_in(chan_a_in), .lock_en_in(lock_a), .cfg_wr_in(cfg_wr_a),
    .cfg_chan_in(cfg_chan_a), .cfg_setpoint_in(cfg_sp_a), .cfg_p_in(cfg_p_a),
    .cfg_i_in(cfg_i_a), .cfg_d_in(cfg_d_a), .data_out(data_a_out),
    .chan_out(chan_a_out), .data_dv_out(dv_a_out)
  );

  pid_filter_mc #(.N_CHAN(6), .W_INT(16)) u_dut_b (
    .clk_in(clk), .n_rst_in(n_rst), .data_dv_in(dv_b_in), .data_in(data_b_in),
    .chan_in(chan_b_in), .lock_en_in(lock_b), .cfg_wr_in(cfg_wr_b),
    .cfg_chan_in(cfg_chan_b), .cfg_setpoint_in(cfg_sp_b), .cfg_p_in(cfg_p_b),
    .cfg_i_in(cfg_i_b), .cfg_d_in(cfg_d_b), .data_out(data_b_out),
    .chan_out(chan_b_out), .data_dv_out(dv_b_out)
  );

  typedef struct {int ch; int val; int cyc;} exp_t;
  typedef struct {int ch; int dat; bit ev; int exp;} vec_t;
  exp_t qa[$];
  exp_t qb[$];
  vec_t steady[4];
  vec_t windup[9];

  // Scalar reference for instance A (26-bit integrator, 18-bit output).
  int     m_sp[8], m_p[8], m_i[8], m_d[8], m_ep[8];
  longint m_int[8];

  function automatic int model_a(input int ch, input int x);
    longint e, integ, d, u;
    longint lim;
    lim = 64'sd1 <<< 25;
    e = longint'(m_sp[ch]) - x;
    integ = m_int[ch] + e;
`ifdef PID_INT_CLAMP_EN
    if (integ > lim - 1) integ = lim - 1;
    else if (integ < -(lim - 1)) integ = -(lim - 1);
`else
    if (integ >= lim) integ = integ - 2 * lim;
    else if (integ < -lim) integ = integ + 2 * lim;
`endif
    d = e - m_ep[ch];
    u = m_p[ch] * e + m_i[ch] * integ + m_d[ch] * d;
    m_int[ch] = integ;
    m_ep[ch]  = int'(e);
    if (u > 131071) u = 131071;
    else if (u < -131072) u = -131072;
    return int'(u);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 8; c++) begin
      m_sp[c] = 0; m_p[c] = 0; m_i[c] = 0; m_d[c] = 0; m_ep[c] = 0; m_int[c] = 0;
    end
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (dv_a_out) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_spurious: got pulse data=%0d chan=%0d at cyc %0d, expected none",
                 data_a_out, chan_a_out, cyc);
      end else begin
        e = qa.pop_front();
        if (int'(data_a_out) != e.val || int'(chan_a_out) != e.ch || cyc != e.cyc) begin
          errors++;
          $display("FAIL a_result: got data=%0d chan=%0d cyc=%0d, expected data=%0d chan=%0d cyc=%0d",
                   data_a_out, chan_a_out, cyc, e.val, e.ch, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (dv_b_out) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_spurious: got pulse data=%0d chan=%0d at cyc %0d, expected none",
                 data_b_out, chan_b_out, cyc);
      end else begin
        e = qb.pop_front();
        if (int'(data_b_out) != e.val || int'(chan_b_out) != e.ch || cyc != e.cyc) begin
          errors++;
          $display("FAIL b_result: got data=%0d chan=%0d cyc=%0d, expected data=%0d chan=%0d cyc=%0d",
                   data_b_out, chan_b_out, cyc, e.val, e.ch, e.cyc);
        end
      end
    end
  end

  task automatic send_a(input int ch, input int x, input bit use_const, input int cval);
    int m;
    @(posedge clk); #1;
    dv_a_in = 1'b1; chan_a_in = 3'(ch); data_a_in = 18'(x);
    lock_a = lock_mask_a; cfg_wr_a = 1'b0;
    if (lock_mask_a[ch]) begin
      m = model_a(ch, x);
      qa.push_back('{ch, use_const ? cval : m, cyc + 5});
    end else begin
      m_int[ch] = 0; m_ep[ch] = 0;
    end
  endtask

  task automatic cfg_a(input bit now, input int ch, input int sp, input int p,
                       input int i, input int d);
    if (!now) begin
      @(posedge clk); #1;
      dv_a_in = 1'b0;
    end
    cfg_wr_a = 1'b1; cfg_chan_a = 3'(ch);
    cfg_sp_a = 16'(sp); cfg_p_a = 16'(p); cfg_i_a = 16'(i); cfg_d_a = 16'(d);
    m_sp[ch] = sp; m_p[ch] = p; m_i[ch] = i; m_d[ch] = d;
  endtask

  task automatic drain_a();
    @(posedge clk); #1;
    dv_a_in = 1'b0; cfg_wr_a = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (qa.size() == 0) break;
      @(negedge clk);
    end
    if (qa.size() != 0) begin
      checks++; errors++;
      $display("FAIL a_timeout: %0d results outstanding, expected 0", qa.size());
      qa.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic send_b(input int ch, input int x, input bit ev, input int val);
    @(posedge clk); #1;
    dv_b_in = 1'b1; chan_b_in = 3'(ch); data_b_in = 18'(x); cfg_wr_b = 1'b0;
    if (ev) qb.push_back('{ch, val, cyc + 5});
  endtask

  task automatic drain_b();
    @(posedge clk); #1;
    dv_b_in = 1'b0; cfg_wr_b = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (qb.size() == 0) break;
      @(negedge clk);
    end
    if (qb.size() != 0) begin
      checks++; errors++;
      $display("FAIL b_timeout: %0d results outstanding, expected 0", qb.size());
      qb.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    steady[0] = '{0, 6000, 1'b1, -90000};
    steady[1] = '{0, 6000, 1'b1, -96000};
    steady[2] = '{0, 6000, 1'b1, -114000};
    steady[3] = '{0, 6000, 1'b1, -131072};

    windup[0] = '{0, 6000, 1'b1, -6000};
    windup[1] = '{0, 6000, 1'b1, -12000};
    windup[2] = '{0, 6000, 1'b1, -18000};
    windup[3] = '{6, 6000, 1'b0, 0};
    windup[4] = '{7, 6000, 1'b0, 0};
    windup[5] = '{0, 6000, 1'b1, -24000};
    windup[6] = '{0, 6000, 1'b1, -30000};
`ifdef PID_INT_CLAMP_EN
    windup[7] = '{0, 6000, 1'b1, -32767};
    windup[8] = '{0, 6000, 1'b1, -32767};
`else
    windup[7] = '{0, 6000, 1'b1, 29536};
    windup[8] = '{0, 6000, 1'b1, 23536};
`endif

    model_reset();
    n_rst = 1'b0;
    dv_a_in = 1'b0; data_a_in = '0; chan_a_in = '0; lock_a = '1; lock_mask_a = '1;
    cfg_wr_a = 1'b0; cfg_chan_a = '0; cfg_sp_a = '0; cfg_p_a = '0; cfg_i_a = '0; cfg_d_a = '0;
    dv_b_in = 1'b0; data_b_in = '0; chan_b_in = '0; lock_b = '1;
    cfg_wr_b = 1'b0; cfg_chan_b = '0; cfg_sp_b = '0; cfg_p_b = '0; cfg_i_b = '0; cfg_d_b = '0;

    #12;
    chk("rst_data_a", data_a_out, 0);
    chk("rst_chan_a", chan_a_out, 0);
    chk("rst_dv_a", dv_a_out, 0);
    chk("rst_data_b", data_b_out, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Steady error on ch0.
    cfg_a(1'b0, 0, 0, 10, 3, 2);
    for (int k = 0; k < 4; k++) send_a(steady[k].ch, steady[k].dat, 1'b1, steady[k].exp);
    drain_a();

    // Lock toggle; the third locked sample is still in S0 when lock drops.
    cfg_a(1'b0, 0, 0, 2, 1, 1);
    send_a(0, 1000, 1'b0, 0);
    send_a(0, -500, 1'b0, 0);
    send_a(0, 2000, 1'b0, 0);
    lock_mask_a[0] = 1'b0;
    send_a(0, 3000, 1'b0, 0);
    send_a(0, 3000, 1'b0, 0);
    lock_mask_a[0] = 1'b1;
    send_a(0, 1000, 1'b1, -4000);
    drain_a();

    // Coefficient write racing a sample on the same channel.
    cfg_a(1'b0, 0, 0, 10, 0, 0);
    send_a(0, 100, 1'b1, -1000);
    cfg_a(1'b1, 0, 0, 20, 0, 0);
    send_a(0, 100, 1'b1, -2000);
    drain_a();

    // Interleaved ch0 / ch3, back to back.
    cfg_a(1'b0, 0, 0, 1, 1, 1);
    cfg_a(1'b0, 3, 100, 3, 2, -1);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) send_a(0, 6000, 1'b0, 0);
      else send_a(3, 4444, 1'b0, 0);
    end
    drain_a();

    // Narrow integrator with invalid channel tags mixed in.
    @(posedge clk); #1;
    cfg_wr_b = 1'b1; cfg_chan_b = 3'd0;
    cfg_sp_b = 16'sd0; cfg_p_b = 16'sd0; cfg_i_b = 16'sd1; cfg_d_b = 16'sd0;
    for (int k = 0; k < 9; k++) send_b(windup[k].ch, windup[k].dat, windup[k].ev, windup[k].exp);
    drain_b();

    // Reset with three samples in flight.
    send_a(0, 500, 1'b0, 0);
    send_a(3, 500, 1'b0, 0);
    send_a(0, 500, 1'b0, 0);
    @(posedge clk); #1;
    dv_a_in = 1'b0;
    n_rst = 1'b0;
    qa.delete();
    model_reset();
    #1;
    chk("midrst_data_a", data_a_out, 0);
    chk("midrst_chan_a", chan_a_out, 0);
    chk("midrst_dv_a", dv_a_out, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    send_a(0, 1234, 1'b1, 0);
    drain_a();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
